// File: rtl/order_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// order_pkg : shared sizing and parameter-check helpers for order_nd_sort
// Rev 1.0
// ----------------------------------------------------------------------------
package order_pkg;

  localparam int c_NUM_MIN = 3;
  localparam int c_NUM_MAX = 31;

  // One transposition stage per element guarantees a full sort for odd NUM.
  function automatic int stage_count(input int num);
    return num;
  endfunction

  function automatic int median_idx(input int num);
    return (num - 1) / 2;
  endfunction

  function automatic int pair_count(input int num);
    return (num - 1) / 2;
  endfunction

  function automatic bit tagw_ok(input int num, input int tagw);
    return (tagw > 0) && (tagw < 31) && ((1 << tagw) >= num);
  endfunction

  function automatic bit params_ok(input int num, input int tagw);
    return (num >= c_NUM_MIN) && (num <= c_NUM_MAX) && ((num % 2) == 1)
           && tagw_ok(num, tagw);
  endfunction

endpackage
`default_nettype wire

// File: rtl/order_cas.sv
`default_nettype none
// ----------------------------------------------------------------------------
// order_cas : stable unsigned compare-exchange cell; ORDER_IDX_TAG_EN adds tags
// Rev 1.0
// ----------------------------------------------------------------------------
module order_cas
  import order_pkg::*;
#(
  parameter int DSIZE = 8
`ifdef ORDER_IDX_TAG_EN
  , parameter int TAGW = 5
`endif
) (
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
`ifdef ORDER_IDX_TAG_EN
  input  logic [TAGW-1:0]  a_tag,
  input  logic [TAGW-1:0]  b_tag,
  output logic [TAGW-1:0]  min_tag,
  output logic [TAGW-1:0]  max_tag,
`endif
  output logic [DSIZE-1:0] min,
  output logic [DSIZE-1:0] max
);

  // Strict compare keeps equal keys in their original order.
  logic w_swap;
  assign w_swap = (a > b);

  assign min = w_swap ? b : a;
  assign max = w_swap ? a : b;

`ifdef ORDER_IDX_TAG_EN
  assign min_tag = w_swap ? b_tag : a_tag;
  assign max_tag = w_swap ? a_tag : b_tag;
`endif

endmodule
`default_nettype wire

// File: rtl/order_nd_sort.sv
`default_nettype none
// ----------------------------------------------------------------------------
// order_nd_sort : pipelined odd-even transposition sorter with median output;
//                 ORDER_IDX_TAG_EN adds per-element input-index tags (out_tag)
// Rev 1.0
// ----------------------------------------------------------------------------
module order_nd_sort
  import order_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int NUM   = 25,
  parameter int TAGW  = 5
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM*DSIZE-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM*DSIZE-1:0] out_data,
`ifdef ORDER_IDX_TAG_EN
  output logic [NUM*TAGW-1:0]  out_tag,
`endif
  output logic [DSIZE-1:0]     out_median
);

  localparam int c_STAGES = stage_count(NUM);
  localparam int c_MED    = median_idx(NUM);
  localparam int c_PAIRS  = pair_count(NUM);

  if (!params_ok(NUM, TAGW)) begin : g_param_check
    $error("order_nd_sort: NUM must be odd within 3..31 and 2**TAGW >= NUM");
  end

  logic [DSIZE-1:0]    w_sin  [c_STAGES][NUM];
  logic [DSIZE-1:0]    w_sout [c_STAGES][NUM];
  logic [DSIZE-1:0]    r_data [c_STAGES][NUM];
`ifdef ORDER_IDX_TAG_EN
  logic [TAGW-1:0]     w_tin  [c_STAGES][NUM];
  logic [TAGW-1:0]     w_tout [c_STAGES][NUM];
  logic [TAGW-1:0]     r_tag  [c_STAGES][NUM];
`endif
  logic [c_STAGES-1:0] r_valid;
  logic                w_adv;

  // The whole pipeline moves together; it only freezes on an unaccepted result.
  assign w_adv     = out_ready | ~out_valid;
  assign in_ready  = w_adv;
  assign out_valid = r_valid[c_STAGES-1];

  for (genvar s = 0; s < c_STAGES; s++) begin : g_stage
    localparam int c_OFF = s % 2;

    for (genvar k = 0; k < NUM; k++) begin : g_in
      if (s == 0) begin : g_first
        assign w_sin[s][k] = in_data[k*DSIZE +: DSIZE];
`ifdef ORDER_IDX_TAG_EN
        localparam logic [TAGW-1:0] c_IDX = TAGW'(k);
        assign w_tin[s][k] = c_IDX;
`endif
      end else begin : g_chain
        assign w_sin[s][k] = r_data[s-1][k];
`ifdef ORDER_IDX_TAG_EN
        assign w_tin[s][k] = r_tag[s-1][k];
`endif
      end
    end

    for (genvar i = 0; i < c_PAIRS; i++) begin : g_pair
      localparam int c_LO = c_OFF + 2*i;
      order_cas #(
        .DSIZE(DSIZE)
`ifdef ORDER_IDX_TAG_EN
        , .TAGW(TAGW)
`endif
      ) u_cas (
        .a       (w_sin[s][c_LO]),
        .b       (w_sin[s][c_LO+1]),
`ifdef ORDER_IDX_TAG_EN
        .a_tag   (w_tin[s][c_LO]),
        .b_tag   (w_tin[s][c_LO+1]),
        .min_tag (w_tout[s][c_LO]),
        .max_tag (w_tout[s][c_LO+1]),
`endif
        .min     (w_sout[s][c_LO]),
        .max     (w_sout[s][c_LO+1])
      );
    end

    // With odd NUM exactly one end slot is left unpaired in every stage.
    if (c_OFF == 0) begin : g_pass_top
      assign w_sout[s][NUM-1] = w_sin[s][NUM-1];
`ifdef ORDER_IDX_TAG_EN
      assign w_tout[s][NUM-1] = w_tin[s][NUM-1];
`endif
    end else begin : g_pass_bottom
      assign w_sout[s][0] = w_sin[s][0];
`ifdef ORDER_IDX_TAG_EN
      assign w_tout[s][0] = w_tin[s][0];
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int s = 0; s < c_STAGES; s++) begin
        for (int k = 0; k < NUM; k++) begin
          r_data[s][k] <= '0;
`ifdef ORDER_IDX_TAG_EN
          r_tag[s][k]  <= '0;
`endif
        end
      end
    end else if (w_adv) begin
      r_valid <= {r_valid[c_STAGES-2:0], in_valid};
      for (int s = 0; s < c_STAGES; s++) begin
        for (int k = 0; k < NUM; k++) begin
          r_data[s][k] <= w_sout[s][k];
`ifdef ORDER_IDX_TAG_EN
          r_tag[s][k]  <= w_tout[s][k];
`endif
        end
      end
    end
  end

  for (genvar k = 0; k < NUM; k++) begin : g_out
    assign out_data[k*DSIZE +: DSIZE] = r_data[c_STAGES-1][k];
`ifdef ORDER_IDX_TAG_EN
    assign out_tag[k*TAGW +: TAGW]    = r_tag[c_STAGES-1][k];
`endif
  end

  assign out_median = r_data[c_STAGES-1][c_MED];

endmodule
`default_nettype wire

// File: doc/order_nd_sort.md
ORDER_ND_SORT -- requirements
Module: order_nd_sort

Interface
REQ-001 Parameter DSIZE, default 8: bit width of each element.
REQ-002 Parameter NUM, default 25: element count per vector; legal range 3..31, odd only.
REQ-003 Parameter TAGW, default 5: index tag width, SHALL satisfy 2**TAGW >= NUM.
REQ-004 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  reset; synchronous, active-low.
REQ-006 Port in_valid  input  1  in_data holds a vector to accept.
REQ-007 Port in_ready  output  1  block can accept a vector this cycle.
REQ-008 Port in_data  input  NUM*DSIZE  unsigned elements; element k at bits [k*DSIZE +: DSIZE].
REQ-009 Port out_valid  output  1  out_data/out_median/out_tag hold a sorted result.
REQ-010 Port out_ready  input  1  downstream accepts the result this cycle.
REQ-011 Port out_data  output  NUM*DSIZE  sorted vector, ascending; slot 0 = minimum.
REQ-012 Port out_median  output  DSIZE  equal to out_data slot (NUM-1)/2.
REQ-013 Port out_tag  output  NUM*TAGW  original input index of each output slot; present only with ORDER_IDX_TAG_EN.

Function
REQ-014 Sort network SHALL be odd-even transposition: NUM registered stages; stage s compares pairs (2i,2i+1) for even s, (2i+1,2i+2) for odd s.
REQ-015 Compare-exchange SHALL swap only when lower slot > upper slot (strict, unsigned), giving stable order for equal keys.
REQ-016 Each stage SHALL carry a valid bit; pipeline advances as one unit by enable adv = out_ready | ~out_valid.
REQ-017 in_ready SHALL equal adv (combinational); a vector is accepted when in_valid & in_ready.
REQ-018 Latency SHALL be exactly NUM cycles from acceptance to out_valid with out_ready held high.
REQ-019 Throughput SHALL be one vector per cycle with no stall.
REQ-020 When adv=0, every stage register and valid bit SHALL hold; no vector is lost or duplicated.
REQ-021 Acceptance cycle with in_valid=0 SHALL insert a bubble (stage-0 valid=0); data registers may still load.
REQ-022 out_data/out_median/out_tag SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 Simultaneous output drain and input accept in one cycle SHALL be legal and lossless.

Reset
REQ-024 While rst_n=0 at a clock edge: all stage valid bits cleared, all data and tag registers cleared to 0.
REQ-025 After reset: out_valid=0, out_data=0, out_median=0, out_tag=0, in_ready=1.
REQ-026 Reset mid-operation SHALL discard all in-flight vectors; no result for them ever appears.

Configuration
REQ-027 Macro ORDER_IDX_TAG_EN defined: each element carries a TAGW tag initialised to its input index k, swapped with its data; out_tag port present.
REQ-028 Macro ORDER_IDX_TAG_EN undefined: no tag registers, no out_tag port; all other behaviour identical.

Structure
REQ-029 Shared package order_pkg SHALL hold the stage-count function, median-index function and tag-width check constant.
REQ-030 Compare-exchange cell SHALL be sub-module order_cas (inputs a, b plus optional tags; outputs min, max), instantiated per pair per stage.
REQ-031 Elaboration SHALL fail for even NUM, NUM<3, NUM>31 or 2**TAGW < NUM.

Verification
REQ-032 NUM=25, input k = 24-k, out_ready=1 -> after 25 cycles out_data slot k = k, out_median=12.
REQ-033 Back-to-back 30 random vectors, out_ready=1 -> 30 results, one per cycle, each matching a reference sort, in order.
REQ-034 out_ready low for 7 cycles while out_valid=1 -> outputs frozen, in_ready=0, no loss; resumes in order when released.
REQ-035 ORDER_IDX_TAG_EN, all inputs = 8'h55 -> out_data all 8'h55, out_tag slot k = k (stability).
REQ-036 rst_n low one cycle at cycle 10 with 10 vectors in flight -> out_valid stays 0 until a new post-reset vector completes 25 cycles later.
REQ-037 NUM=3, DSIZE=16, input {16'hFFFF,16'h0000,16'h8000} -> out_data {16'h0000,16'h8000,16'hFFFF}, out_median 16'h8000, latency 3.
